// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between the fetch stage (reads)
//   and the memory stage (loads/stores). One transaction outstanding at a time.
//   The data side has fixed priority. A starvation counter forces fetch to win
//   after STARVE_LIMIT contended cycles (0 disables the override).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   if_req_i/if_addr_i  : fetch read request
//   if_rvalid_o/if_rdata_o : fetch response (one-cycle pulse)
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i : data load/store request
//   dm_rvalid_o/dm_rdata_o : load response (one-cycle pulse)
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o : memory request side
//   mem_gnt_i/mem_rvalid_i/mem_rdata_i        : memory grant and read data
//   stall_if_o/stall_mem_o : per-stage hold signals to the hazard logic
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic        dm_rvalid_o,
    output logic [31:0] dm_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_if_o,
    output logic        stall_mem_o
);

    // Counter width must stay >= 1 even when the override is disabled.
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;

    state_t        state, next_state;
    logic          owner_dm;      // 1 = memory stage owns the transaction
    logic          issue_we;
    logic [31:0]   issue_addr;
    logic [31:0]   issue_wdata;
    logic [CW-1:0] starve_cnt;

    logic force_if, win_dm, latch, cur_dm, store_done;

    assign if_rdata_o = mem_rdata_i;
    assign dm_rdata_o = mem_rdata_i;

    assign force_if = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);
    assign win_dm   = dm_req_i & ~(if_req_i & force_if);

    always_comb begin
        next_state  = state;
        mem_req_o   = 1'b0;
        mem_we_o    = issue_we;
        mem_addr_o  = issue_addr;
        mem_wdata_o = issue_wdata;
        if_rvalid_o = 1'b0;
        dm_rvalid_o = 1'b0;
        latch       = 1'b0;
        case (state)
            IDLE: begin
                if (if_req_i | dm_req_i) begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = win_dm ? dm_we_i : 1'b0;
                    mem_addr_o  = win_dm ? dm_addr_i : if_addr_i;
                    mem_wdata_o = win_dm ? dm_wdata_i : 32'h0;
                    latch       = 1'b1;
                    if (!mem_gnt_i)     next_state = HOLD;
                    else if (!mem_we_o) next_state = RESP;
                end
            end
            HOLD: begin
                // Fields come from the issue registers so a withdrawn
                // request (e.g. fetch flush) cannot disturb the bus.
                mem_req_o = 1'b1;
                if (mem_gnt_i) next_state = issue_we ? IDLE : RESP;
            end
            RESP: begin
                if (mem_rvalid_i) begin
                    if_rvalid_o = ~owner_dm;
                    dm_rvalid_o = owner_dm;
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (reset) begin
            mem_req_o   = 1'b0;
            if_rvalid_o = 1'b0;
            dm_rvalid_o = 1'b0;
        end
    end

    // In IDLE the store being granted belongs to this cycle's winner.
    assign cur_dm      = (state == IDLE) ? win_dm : owner_dm;
    assign store_done  = mem_gnt_i & mem_req_o & mem_we_o & cur_dm;
    assign stall_if_o  = if_req_i & ~if_rvalid_o;
    assign stall_mem_o = dm_req_i & ~(dm_we_i ? store_done : dm_rvalid_o);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner_dm    <= 1'b0;
            issue_we    <= 1'b0;
            issue_addr  <= 32'h0;
            issue_wdata <= 32'h0;
            starve_cnt  <= '0;
        end else begin
            state <= next_state;
            if (latch) begin
                owner_dm    <= win_dm;
                issue_we    <= mem_we_o;
                issue_addr  <= mem_addr_o;
                issue_wdata <= mem_wdata_o;
                if (!win_dm)
                    starve_cnt <= '0;
                else if (if_req_i && starve_cnt != LIMIT)
                    starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic checked against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rv;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_rv;
    logic [31:0] dm_rdata;
    logic        mreq, mwe;
    logic [31:0] maddr, mwdata;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        stall_if, stall_mem;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(rst),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .if_rvalid_o(if_rv), .if_rdata_o(if_rdata),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_rvalid_o(dm_rv), .dm_rdata_o(dm_rdata),
        .mem_req_o(mreq), .mem_we_o(mwe), .mem_addr_o(maddr), .mem_wdata_o(mwdata),
        .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
        .stall_if_o(stall_if), .stall_mem_o(stall_mem)
    );

    // ---------------- reference model (transaction record) ----------------
    bit        m_busy, m_granted, m_dm, m_we;
    bit [31:0] m_addr, m_wd;
    int        m_starve;
    bit        n_busy, n_granted, n_dm, n_we;
    bit [31:0] n_addr, n_wd;
    int        n_starve;

    task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_eval(output logic [133:0] e);
        logic req, we, irv, drv, sdone, dmw;
        logic [31:0] addr, wd;
        req = 0; we = 0; addr = 0; wd = 0; irv = 0; drv = 0; sdone = 0;
        n_busy = m_busy; n_granted = m_granted; n_dm = m_dm; n_we = m_we;
        n_addr = m_addr; n_wd = m_wd; n_starve = m_starve;
        if (rst) begin
            n_busy = 0; n_granted = 0; n_starve = 0;
        end else if (!m_busy) begin
            if (if_req || dm_req) begin
                dmw  = dm_req && !(if_req && LIM != 0 && m_starve == LIM);
                req  = 1;
                we   = dmw ? dm_we : 1'b0;
                addr = dmw ? dm_addr : if_addr;
                wd   = dmw ? dm_wdata : 32'h0;
                sdone = gnt && we;
                if (!dmw) n_starve = 0;
                else if (if_req) n_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
                if (!(gnt && we)) begin
                    n_busy = 1; n_granted = gnt; n_dm = dmw; n_we = we;
                    n_addr = addr; n_wd = wd;
                end
            end
        end else if (!m_granted) begin
            req = 1; we = m_we; addr = m_addr; wd = m_wd;
            sdone = gnt && m_we && m_dm;
            if (gnt) begin
                if (m_we) n_busy = 0;
                else n_granted = 1;
            end
        end else if (rvalid) begin
            irv = !m_dm; drv = m_dm; n_busy = 0; n_granted = 0;
        end
        e = {req, we, addr, wd, irv, drv, if_req && !irv,
             dm_req && !(dm_we ? sdone : drv), rdata, rdata};
    endtask

    // Sample at the falling edge, checking every cycle against the model.
    task automatic sample();
        logic [133:0] e, a;
        @(negedge clk);
        model_eval(e);
        a = {mreq, mreq & mwe, mreq ? maddr : 32'h0, mreq ? mwdata : 32'h0,
             if_rv, dm_rv, stall_if, stall_mem, if_rdata, dm_rdata};
        chk("model", a, e);
    endtask

    task automatic advance();
        @(posedge clk);
        m_busy = n_busy; m_granted = n_granted; m_dm = n_dm; m_we = n_we;
        m_addr = n_addr; m_wd = n_wd; m_starve = n_starve;
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
        dm_wdata = 0; gnt = 0; rvalid = 0; rdata = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic rst, ifr; logic [31:0] ifa;
        logic dmr, dmw; logic [31:0] dma, dmd;
        logic g, rv; logic [31:0] rd;
        logic x_req, x_we; logic [31:0] x_addr;
        logic x_irv, x_drv, x_sif, x_smem;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [37:0] va, ve;
        int dm_pulses;
        idle_inputs();
        rst = 1;
        m_busy = 0; m_granted = 0; m_dm = 0; m_we = 0; m_addr = 0; m_wd = 0; m_starve = 0;

        //         rst ifr ifa    dmr dmw dma     dmd           g  rv rd            req we addr  irv drv sif smem
        vecs[0] = '{1, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 0};
        vecs[1] = '{1, 1, 32'h10, 1, 0, 32'h40,  32'h0,        1, 1, 32'h5,        0, 0, 32'h0,  0, 0, 1, 1};
        vecs[2] = '{0, 1, 32'h10, 0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        1, 0, 32'h10, 0, 0, 1, 0};
        vecs[3] = '{0, 1, 32'h10, 0, 0, 32'h0,   32'h0,        0, 1, 32'h00510093, 0, 0, 32'h0,  1, 0, 0, 0};
        vecs[4] = '{0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 0};
        vecs[5] = '{0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 1, 32'hBAD,      0, 0, 32'h0,  0, 0, 0, 0};
        vecs[6] = '{0, 1, 32'h20, 1, 1, 32'h100, 32'hDEADBEEF, 1, 0, 32'h0,        1, 1, 32'h100,0, 0, 1, 0};
        vecs[7] = '{0, 1, 32'h20, 0, 0, 32'h0,   32'h0,        1, 0, 32'h0,        1, 0, 32'h20, 0, 0, 1, 0};
        vecs[8] = '{0, 1, 32'h20, 0, 0, 32'h0,   32'h0,        0, 1, 32'h13,       0, 0, 32'h0,  1, 0, 0, 0};
        vecs[9] = '{0, 0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 0};

        for (int i = 0; i < 10; i++) begin
            rst = vecs[i].rst; if_req = vecs[i].ifr; if_addr = vecs[i].ifa;
            dm_req = vecs[i].dmr; dm_we = vecs[i].dmw; dm_addr = vecs[i].dma;
            dm_wdata = vecs[i].dmd; gnt = vecs[i].g; rvalid = vecs[i].rv; rdata = vecs[i].rd;
            sample();
            va = {mreq, mreq & mwe, mreq ? maddr : 32'h0, if_rv, dm_rv, stall_if, stall_mem};
            ve = {vecs[i].x_req, vecs[i].x_we, vecs[i].x_addr, vecs[i].x_irv,
                  vecs[i].x_drv, vecs[i].x_sif, vecs[i].x_smem};
            chk($sformatf("vec%0d", i), 134'(va), 134'(ve));
            if (i == 3) chk("vec3_rdata", 134'(if_rdata), 134'(32'h00510093));
            advance();
        end

        // ---- starvation: back-to-back loads while fetch waits ----
        for (int k = 1; k <= 6; k++) begin
            idle_inputs();
            if_req = 1; if_addr = 32'h300; dm_req = 1; dm_addr = 32'h200; gnt = 1;
            sample();
            chk($sformatf("starve_win%0d", k), 134'(maddr),
                134'((k == 5) ? 32'h300 : 32'h200));
            advance();
            gnt = 0; rvalid = 1; rdata = 32'(k);
            sample();
            chk($sformatf("starve_rsp%0d", k), 134'({if_rv, dm_rv}),
                134'((k == 5) ? 2'b10 : 2'b01));
            advance();
        end

        // ---- HOLD keeps the issued address while the requester changes it ----
        idle_inputs();
        dm_pulses = 0;
        dm_req = 1; dm_addr = 32'h40;
        sample(); chk("hold_issue", 134'({mreq, maddr}), 134'({1'b1, 32'h40})); advance();
        dm_addr = 32'h44;
        for (int k = 0; k < 3; k++) begin
            gnt = (k == 2);
            sample();
            chk($sformatf("hold_addr%0d", k), 134'({mreq, maddr}), 134'({1'b1, 32'h40}));
            dm_pulses += int'(dm_rv);
            advance();
        end
        gnt = 0; rvalid = 1; rdata = 32'h1234;
        sample(); dm_pulses += int'(dm_rv);
        chk("hold_rdata", 134'(dm_rdata), 134'(32'h1234)); advance();
        dm_req = 0; rvalid = 1;
        sample(); dm_pulses += int'(dm_rv); advance();
        rvalid = 0;
        sample(); dm_pulses += int'(dm_rv); advance();
        chk("hold_pulses", 134'(dm_pulses), 134'(1));

        // ---- reset during RESP drops the late response ----
        idle_inputs();
        if_req = 1; if_addr = 32'h80; gnt = 1;
        sample(); chk("rst_issue", 134'(mreq), 134'(1)); advance();
        rst = 1; gnt = 0;
        sample(); chk("rst_quiet", 134'({mreq, if_rv, dm_rv}), 134'(0)); advance();
        rst = 0; rvalid = 1; if_addr = 32'h84;
        sample();
        chk("rst_late_rv", 134'({if_rv, dm_rv, mreq, maddr}), 134'({2'b00, 1'b1, 32'h84}));
        advance();
        rvalid = 0; gnt = 1;
        sample(); chk("rst_hold", 134'({mreq, maddr}), 134'({1'b1, 32'h84})); advance();
        gnt = 0; rvalid = 1; rdata = 32'h77;
        sample(); chk("rst_rsp", 134'({if_rv, if_rdata}), 134'({1'b1, 32'h77})); advance();

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 63) == 0);
            if_req   = ($urandom_range(0, 3) != 0);
            if_addr  = {$urandom_range(0, 32'hFFFF), 2'b00} & 32'hFFFC;
            dm_req   = ($urandom_range(0, 1) == 1);
            dm_we    = ($urandom_range(0, 1) == 1);
            dm_addr  = $urandom & 32'hFFFF_FFFC;
            dm_wdata = $urandom;
            gnt      = ($urandom_range(0, 9) < 6);
            rvalid   = ($urandom_range(0, 9) < 4);
            rdata    = $urandom;
            sample();
            advance();
        end

        idle_inputs();
        sample();
        advance();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
